// File: rtl/sp_ram_param.sv
// Single-port RAM with byte-lane write enables, selectable write-port read behaviour
// and a hardware clear sweep that zeroes every word after reset or on request.
module sp_ram_param #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 6,
    parameter int WR_MODE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req,
    input  logic                   we,
    input  logic [DATA_W/8-1:0]    be,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic                   clr,
    output logic [DATA_W-1:0]      rdata,
    output logic                   rvalid,
    output logic                   busy
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W/8;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   old_word;
    logic [DATA_W-1:0]   merged_word;
    logic [DATA_W-1:0]   rdata_d;
    logic                rvalid_d;
    logic                rd_acc;
    logic                wr_acc;

    // Access handshake: an access is taken at every rising edge where req=1 while
    // IDLE and clr=0; there is no back-pressure other than busy, and a clr at the
    // same edge takes priority and discards the access.
    assign busy   = (state_q == CLEAR);
    assign rd_acc = (state_q == IDLE) && !clr && req && !we;
    assign wr_acc = (state_q == IDLE) && !clr && req && we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rdata     <= rdata_d;
            rvalid    <= rvalid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clr) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        old_word    = mem[addr];
        merged_word = old_word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                merged_word[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata_d  = rdata;
        rvalid_d = 1'b0;
        if (rd_acc) begin
            rdata_d  = old_word;
            rvalid_d = 1'b1;
        end else if (wr_acc) begin
            if (WR_MODE == 0) begin
                rdata_d  = old_word;
                rvalid_d = 1'b1;
            end else if (WR_MODE == 1) begin
                rdata_d  = merged_word;
                rvalid_d = 1'b1;
            end
        end
    end

    // Storage carries no reset; the sweep zeroes it once reset is released.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == CLEAR) begin
                mem[clr_cnt_q] <= '0;
            end else if (wr_acc) begin
                mem[addr] <= merged_word;
            end
        end
    end

endmodule

// File: tb/tb_sp_ram_param.sv
// Bench for sp_ram_param: three instances (one per WR_MODE) share stimulus and are
// checked each cycle against a behavioural model through per-mode expected queues.
module tb_sp_ram_param;

    localparam int DW = 16;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic          clr = 1'b0;
    logic [1:0]    be = '0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata [3];
    logic          rvalid [3];
    logic          busy [3];

    for (genvar m = 0; m < 3; m++) begin : g_dut
        sp_ram_param #(.DATA_W(DW), .ADDR_W(AW), .WR_MODE(m)) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .req    (req),
            .we     (we),
            .be     (be),
            .addr   (addr),
            .wdata  (wdata),
            .clr    (clr),
            .rdata  (rdata[m]),
            .rvalid (rvalid[m]),
            .busy   (busy[m])
        );
    end

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected {busy, rvalid, rdata} per mode, pushed at drive time, popped after the edge
    logic [DW+1:0] exp_q0[$];
    logic [DW+1:0] exp_q1[$];
    logic [DW+1:0] exp_q2[$];

    logic [DW-1:0] m_mem [64];
    logic          m_busy;
    logic [AW-1:0] m_cnt;
    logic [DW-1:0] m_rdata [3];
    logic          m_rvalid [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp();
        exp_q0.push_back({m_busy, m_rvalid[0], m_rdata[0]});
        exp_q1.push_back({m_busy, m_rvalid[1], m_rdata[1]});
        exp_q2.push_back({m_busy, m_rvalid[2], m_rdata[2]});
    endtask

    task automatic compare_out(input int m, input logic [DW+1:0] e);
        check($sformatf("rdata_m%0d", m), 32'(rdata[m]), 32'(e[DW-1:0]));
        check($sformatf("rvalid_m%0d", m), 32'(rvalid[m]), 32'(e[DW]));
        check($sformatf("busy_m%0d", m), 32'(busy[m]), 32'(e[DW+1]));
    endtask

    // Drive one cycle of inputs, update the model, then check all DUTs after the edge
    task automatic step(input logic r, input logic w, input logic [1:0] b,
                        input logic [AW-1:0] a, input logic [DW-1:0] d, input logic c);
        logic [DW-1:0] old_w;
        logic [DW-1:0] new_w;
        req = r; we = w; be = b; addr = a; wdata = d; clr = c;
        for (int m = 0; m < 3; m++) m_rvalid[m] = 1'b0;
        if (m_busy) begin
            m_mem[m_cnt] = '0;
            if (m_cnt == 6'd63) m_busy = 1'b0;
            m_cnt = m_cnt + 6'd1;
        end else if (c) begin
            m_busy = 1'b1;
            m_cnt  = '0;
        end else if (r && !w) begin
            for (int m = 0; m < 3; m++) begin
                m_rdata[m]  = m_mem[a];
                m_rvalid[m] = 1'b1;
            end
        end else if (r && w) begin
            old_w = m_mem[a];
            new_w = old_w;
            if (b[0]) new_w[7:0]  = d[7:0];
            if (b[1]) new_w[15:8] = d[15:8];
            m_mem[a] = new_w;
            m_rdata[0] = old_w; m_rvalid[0] = 1'b1;
            m_rdata[1] = new_w; m_rvalid[1] = 1'b1;
        end
        push_exp();
        @(posedge clk);
        #1;
        compare_out(0, exp_q0.pop_front());
        compare_out(1, exp_q1.pop_front());
        compare_out(2, exp_q2.pop_front());
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
    endtask

    // Asserted away from any clock edge so the checks see the asynchronous effect
    task automatic do_reset();
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; clr = 1'b0; be = '0; addr = '0; wdata = '0;
        #1;
        m_busy = 1'b1;
        m_cnt  = '0;
        for (int m = 0; m < 3; m++) begin
            m_rdata[m]  = '0;
            m_rvalid[m] = 1'b0;
            check($sformatf("rst_rdata_m%0d", m), 32'(rdata[m]), 32'h0);
            check($sformatf("rst_rvalid_m%0d", m), 32'(rvalid[m]), 32'h0);
            check($sformatf("rst_busy_m%0d", m), 32'(busy[m]), 32'h1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Runs cycles until busy drops, optionally firing random accesses that must be ignored
    task automatic run_sweep(input string tag, input logic noisy);
        int n;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy[0] !== 1'b1) break;
            if (noisy)
                step(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     6'($urandom_range(0, 63)), 16'($urandom_range(0, 65535)), 1'b1);
            else
                idle();
            n++;
        end
        check(tag, 32'(n), 32'd64);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m_mem[i] = 'x;

        do_reset();
        run_sweep("sweep_after_reset", 1'b0);

        step(1'b1, 1'b0, 2'b00, 6'd0, '0, 1'b0);
        step(1'b1, 1'b0, 2'b00, 6'd31, '0, 1'b0);
        step(1'b1, 1'b0, 2'b00, 6'd63, '0, 1'b0);
        idle();

        step(1'b1, 1'b1, 2'b11, 6'd5, 16'hA5C3, 1'b0);
        step(1'b1, 1'b1, 2'b01, 6'd5, 16'h1234, 1'b0);
        idle();
        step(1'b1, 1'b0, 2'b00, 6'd5, '0, 1'b0);
        check("addr5_merge", 32'(rdata[0]), 32'hA534);

        step(1'b1, 1'b1, 2'b11, 6'd9, 16'h1111, 1'b0);
        idle();
        step(1'b1, 1'b1, 2'b11, 6'd9, 16'h2222, 1'b0);
        check("wr_mode0_old", 32'(rdata[0]), 32'h1111);
        check("wr_mode1_new", 32'(rdata[1]), 32'h2222);
        check("wr_mode2_novalid", 32'(rvalid[2]), 32'h0);
        step(1'b1, 1'b0, 2'b00, 6'd9, '0, 1'b0);

        step(1'b1, 1'b1, 2'b00, 6'd5, 16'hFFFF, 1'b0);
        step(1'b1, 1'b0, 2'b00, 6'd5, '0, 1'b0);

        step(1'b1, 1'b1, 2'b11, 6'd7, 16'hBEEF, 1'b0);
        step(1'b1, 1'b0, 2'b00, 6'd7, '0, 1'b0);
        check("b2b_read7", 32'(rdata[0]), 32'hBEEF);

        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 6'($urandom_range(0, 15)),
                 16'($urandom_range(0, 65535)), 1'b0);
        end

        step(1'b1, 1'b0, 2'b00, 6'd5, '0, 1'b1);
        check("clr_drops_read", 32'(rvalid[0]), 32'h0);
        run_sweep("sweep_after_clr", 1'b1);
        step(1'b1, 1'b0, 2'b00, 6'd5, '0, 1'b0);
        step(1'b1, 1'b0, 2'b00, 6'd7, '0, 1'b0);

        step(1'b0, 1'b0, 2'b00, '0, '0, 1'b1);
        for (int i = 0; i < 20; i++) idle();
        do_reset();
        run_sweep("sweep_after_mid_reset", 1'b1);

        step(1'b1, 1'b1, 2'b11, 6'd3, 16'h5A5A, 1'b0);
        step(1'b1, 1'b0, 2'b00, 6'd3, '0, 1'b0);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sp_ram_param.md
SP_RAM_PARAM -- requirements
Module: sp_ram_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, word width in bits; SHALL be a multiple of 8.
REQ-002 SHALL provide parameter ADDR_W, default 6, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL provide parameter WR_MODE, default 0, write-port read behaviour: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.
REQ-004 SHALL derive NB = DATA_W/8, the number of byte lanes.
REQ-005 Port list:
- clk  input  1  rising-edge clock, sole clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  access request, sampled at rising clk.
- we  input  1  1 = write, 0 = read; qualified by req.
- be  input  NB  byte-lane write enables; be[i] covers wdata[8i+7:8i].
- addr  input  ADDR_W  word address.
- wdata  input  DATA_W  write data.
- clr  input  1  request a full-memory clear sweep.
- rdata  output  DATA_W  registered read data.
- rvalid  output  1  one-cycle pulse marking rdata updated.
- busy  output  1  high while a clear sweep runs; accesses refused.

Function
REQ-010 SHALL implement a two-state FSM: CLEAR and IDLE.
REQ-011 In CLEAR, SHALL write all-zero to word clr_cnt each cycle, incrementing clr_cnt from 0; after writing DEPTH-1, SHALL enter IDLE on that edge.
REQ-012 A sweep SHALL take exactly DEPTH cycles; busy SHALL be 1 throughout CLEAR and 0 in IDLE.
REQ-013 In CLEAR, req and clr SHALL be ignored: no memory change, rvalid stays 0, rdata holds.
REQ-014 In IDLE, clr=1 at an edge SHALL enter CLEAR with clr_cnt=0; a req sampled at that same edge SHALL be dropped (clr wins).
REQ-015 Read (IDLE, req=1, we=0) sampled at edge N: rdata = mem[addr] and rvalid = 1 after edge N; rvalid returns to 0 after edge N+1 unless another qualifying access is sampled.
REQ-016 Write (IDLE, req=1, we=1) at edge N: for each i with be[i]=1, lane i of mem[addr] SHALL take wdata lane i; lanes with be[i]=0 SHALL be unchanged.
REQ-017 On a write, WR_MODE 0: rdata = old mem[addr], rvalid = 1; WR_MODE 1: rdata = merged new word, rvalid = 1; WR_MODE 2: rdata holds, rvalid = 0.
REQ-018 A write with be all-zero SHALL leave memory unchanged; rdata/rvalid follow REQ-017 (old word in modes 0 and 1).
REQ-019 Back-to-back accesses SHALL be accepted every cycle at full throughput; a read of an address written at the preceding edge SHALL return the new data.
REQ-020 req=0 SHALL leave rdata unchanged and drive rvalid 0 after the edge.
REQ-021 Out-of-range addresses SHALL NOT exist: every ADDR_W value maps to a word.

Reset
REQ-030 rst_n=0 SHALL immediately force rdata=0, rvalid=0, busy=1, clr_cnt=0, state CLEAR, independent of clk.
REQ-031 After rst_n rises, the first rising edge SHALL start the sweep at word 0; busy falls DEPTH edges later.
REQ-032 Reset asserted mid-sweep or mid-access SHALL abort it and restart per REQ-030; memory contents need not be retained.

Verification (defaults DATA_W=16, ADDR_W=6, DEPTH=64)
REQ-040 Release reset, hold req=0 -> busy=1 for exactly 64 cycles then 0; reads of 0, 31, 63 return 16'h0000 with one-cycle rvalid.
REQ-041 Write 16'hA5C3 to addr 5 with be=2'b11, then be=2'b01 with wdata 16'h1234 -> read addr 5 returns 16'hA534.
REQ-042 WR_MODE 0/1/2 with mem[9]=16'h1111, write 16'h2222 be=2'b11 -> rdata 16'h1111 rvalid 1 / 16'h2222 rvalid 1 / rdata held rvalid 0.
REQ-043 Pulse clr with a simultaneous read in IDLE -> read dropped (no rvalid), busy 64 cycles, previously written addr 5 reads 16'h0000.
REQ-044 Assert rst_n=0 at sweep cycle 20, release -> busy restarts, deasserts 64 cycles after release; req during busy produces no rvalid.
REQ-045 Consecutive-cycle write addr 7 = 16'hBEEF then read addr 7 -> rdata 16'hBEEF, rvalid high on both cycles (WR_MODE 0).
